// File: rtl/lms_adapt_fir.sv
`default_nettype none
// ============================================================================
//  Module   : lms_adapt_fir
//  Brief    : Time-multiplexed LMS adaptive FIR. One MAC per cycle computes
//             y, the error e = d - y is registered, then each coefficient is
//             optionally nudged by (e * x[k]) >>> MU_SHIFT, one tap per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module lms_adapt_fir #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int FRAC     = 14,
   parameter int TAPS     = 16,
   parameter int MU_SHIFT = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [DATA_W-1:0]  x_in,
   input  logic signed [DATA_W-1:0]  d_in,
   input  logic                      adapt_en,
   input  logic                      coef_clr,
   output logic                      out_valid,
   output logic signed [DATA_W-1:0]  y_out,
   output logic signed [DATA_W-1:0]  e_out,
   input  logic [$clog2(TAPS)-1:0]   coef_sel,
   output logic signed [COEF_W-1:0]  coef_out
);

   localparam int c_IDX_W  = $clog2(TAPS);
   localparam int c_PROD_W = DATA_W + COEF_W;
   localparam int c_ACC_W  = DATA_W + COEF_W + c_IDX_W;
   // Update sum is wide enough for both the coefficient and the e*x product.
   localparam int c_UPD_W  = ((2 * DATA_W > COEF_W) ? 2 * DATA_W : COEF_W) + 1;
   localparam int c_SEL_N  = 2 ** c_IDX_W;

   localparam logic [c_IDX_W-1:0]       c_IDX_LAST = c_IDX_W'(TAPS - 1);
   localparam logic signed [DATA_W-1:0] c_DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] c_DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [COEF_W-1:0] c_COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
   localparam logic signed [COEF_W-1:0] c_COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_FILT = 2'd1;
   localparam logic [1:0] c_ERR  = 2'd2;
   localparam logic [1:0] c_UPD  = 2'd3;

   logic [1:0]                 state_q, state_d;
   logic [c_IDX_W-1:0]         idx_q, idx_d;
   logic signed [c_ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0]   d_q, d_d;
   logic                       adapt_q, adapt_d;
   logic signed [DATA_W-1:0]   y_q, y_d;
   logic signed [DATA_W-1:0]   e_q, e_d;
   logic                       out_valid_q, out_valid_d;
   logic signed [COEF_W-1:0]   coef_out_q, coef_out_d;
   logic signed [DATA_W-1:0]   x_q [TAPS];
   logic signed [DATA_W-1:0]   x_d [TAPS];
   logic signed [COEF_W-1:0]   w_q [TAPS];
   logic signed [COEF_W-1:0]   w_d [TAPS];

   logic signed [COEF_W-1:0]   w_sel;
   logic signed [DATA_W-1:0]   x_sel;
   logic signed [c_PROD_W-1:0] mac_prod;
   logic signed [c_ACC_W-1:0]  y_shift;
   logic signed [DATA_W-1:0]   y_sat;
   logic signed [DATA_W:0]     e_wide;
   logic signed [DATA_W-1:0]   e_sat;
   logic signed [2*DATA_W-1:0] upd_prod;
   logic signed [2*DATA_W-1:0] upd_step;
   logic signed [c_UPD_W-1:0]  upd_sum;
   logic signed [COEF_W-1:0]   w_upd;
   logic signed [COEF_W-1:0]   w_pad [c_SEL_N];

   // The shared MAC and the update path both work on the tap selected by idx.
   assign w_sel    = w_q[idx_q];
   assign x_sel    = x_q[idx_q];
   assign mac_prod = w_sel * x_sel;
   assign y_shift  = acc_q >>> FRAC;
   assign e_wide   = {d_q[DATA_W-1], d_q} - {y_sat[DATA_W-1], y_sat};
   assign upd_prod = e_q * x_sel;
   assign upd_step = upd_prod >>> MU_SHIFT;
   assign upd_sum  = {{(c_UPD_W-COEF_W){w_sel[COEF_W-1]}}, w_sel}
                   + {{(c_UPD_W-2*DATA_W){upd_step[2*DATA_W-1]}}, upd_step};

   // Clamp the scaled accumulator, the error and the updated coefficient.
   always_comb begin
      y_sat = y_shift[DATA_W-1:0];
      if (y_shift[c_ACC_W-1:DATA_W-1] != {(c_ACC_W-DATA_W+1){y_shift[c_ACC_W-1]}}) begin
         y_sat = y_shift[c_ACC_W-1] ? c_DATA_MIN : c_DATA_MAX;
      end
      e_sat = e_wide[DATA_W-1:0];
      if (e_wide[DATA_W] != e_wide[DATA_W-1]) begin
         e_sat = e_wide[DATA_W] ? c_DATA_MIN : c_DATA_MAX;
      end
      w_upd = upd_sum[COEF_W-1:0];
      if (upd_sum[c_UPD_W-1:COEF_W-1] != {(c_UPD_W-COEF_W+1){upd_sum[c_UPD_W-1]}}) begin
         w_upd = upd_sum[c_UPD_W-1] ? c_COEF_MIN : c_COEF_MAX;
      end
   end

   // Readback table padded with zeros so any select value maps to a defined word.
   for (genvar gi = 0; gi < c_SEL_N; gi++) begin : g_pad
      if (gi < TAPS) begin : g_tap
         assign w_pad[gi] = w_q[gi];
      end else begin : g_zero
         assign w_pad[gi] = '0;
      end
   end

   assign coef_out_d = w_pad[coef_sel];
   assign in_ready   = (state_q == c_IDLE) && !coef_clr;
   assign out_valid  = out_valid_q;
   assign y_out      = y_q;
   assign e_out      = e_q;
   assign coef_out   = coef_out_q;

   // Sequencer: accept, filter, form error, optionally adapt; clear overrides all.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      d_d         = d_q;
      adapt_d     = adapt_q;
      y_d         = y_q;
      e_d         = e_q;
      out_valid_d = 1'b0;
      x_d         = x_q;
      w_d         = w_q;
      if (coef_clr) begin
         state_d = c_IDLE;
         idx_d   = '0;
         acc_d   = '0;
         for (int k = 0; k < TAPS; k++) begin
            x_d[k] = '0;
            w_d[k] = '0;
         end
      end else begin
         case (state_q)
            c_IDLE: begin
               if (in_valid) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     x_d[k] = x_q[k-1];
                  end
                  x_d[0]  = x_in;
                  d_d     = d_in;
                  adapt_d = adapt_en;
                  acc_d   = '0;
                  idx_d   = '0;
                  state_d = c_FILT;
               end
            end
            c_FILT: begin
               acc_d = acc_q + {{c_IDX_W{mac_prod[c_PROD_W-1]}}, mac_prod};
               if (idx_q == c_IDX_LAST) begin
                  idx_d   = '0;
                  state_d = c_ERR;
               end else begin
                  idx_d = idx_q + c_IDX_W'(1);
               end
            end
            c_ERR: begin
               y_d         = y_sat;
               e_d         = e_sat;
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = adapt_q ? c_UPD : c_IDLE;
            end
            c_UPD: begin
               w_d[idx_q] = w_upd;
               if (idx_q == c_IDX_LAST) begin
                  idx_d   = '0;
                  state_d = c_IDLE;
               end else begin
                  idx_d = idx_q + c_IDX_W'(1);
               end
            end
            default: state_d = c_IDLE;
         endcase
      end
   end

   // State, datapath and readback registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= c_IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         d_q         <= '0;
         adapt_q     <= 1'b0;
         y_q         <= '0;
         e_q         <= '0;
         out_valid_q <= 1'b0;
         coef_out_q  <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k] <= '0;
            w_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         d_q         <= d_d;
         adapt_q     <= adapt_d;
         y_q         <= y_d;
         e_q         <= e_d;
         out_valid_q <= out_valid_d;
         coef_out_q  <= coef_out_d;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k] <= x_d[k];
            w_q[k] <= w_d[k];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_fir.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lms_adapt_fir
//  Brief    : Directed + random self-checking bench for lms_adapt_fir, with an
//             arithmetic reference model of the LMS filter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lms_adapt_fir;

   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int FRAC     = 14;
   localparam int TAPS     = 4;
   localparam int MU_SHIFT = 12;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] x_in;
   logic signed [DATA_W-1:0] d_in;
   logic                     adapt_en;
   logic                     coef_clr;
   logic                     out_valid;
   logic signed [DATA_W-1:0] y_out;
   logic signed [DATA_W-1:0] e_out;
   logic [1:0]               coef_sel;
   logic signed [COEF_W-1:0] coef_out;

   int     n_assert = 0;
   int     n_fail   = 0;
   longint mw [TAPS];
   longint mx [TAPS];

   lms_adapt_fir #(
      .DATA_W  (DATA_W),
      .COEF_W  (COEF_W),
      .FRAC    (FRAC),
      .TAPS    (TAPS),
      .MU_SHIFT(MU_SHIFT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x_in     (x_in),
      .d_in     (d_in),
      .adapt_en (adapt_en),
      .coef_clr (coef_clr),
      .out_valid(out_valid),
      .y_out    (y_out),
      .e_out    (e_out),
      .coef_sel (coef_sel),
      .coef_out (coef_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop so a stalled design can never hang the run.
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   function automatic longint sat(input longint v, input int w);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < TAPS; k++) begin
         mw[k] = 0;
         mx[k] = 0;
      end
   endtask

   // Reference behaviour of one accepted sample: returns y and e, adapts w.
   task automatic model_step(input int xv, input int dv, input bit ad,
                             output longint y, output longint e);
      longint acc;
      for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = xv;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += mw[k] * mx[k];
      y = sat(acc >>> FRAC, DATA_W);
      e = sat(longint'(dv) - y, DATA_W);
      if (ad) begin
         for (int k = 0; k < TAPS; k++) mw[k] = sat(mw[k] + ((e * mx[k]) >>> MU_SHIFT), COEF_W);
      end
   endtask

   // Wait for in_ready (bounded), present one sample, check result and timing.
   task automatic send(input int xv, input int dv, input bit ad);
      int     el;
      longint y, e;
      el = 0;
      while (!in_ready && el < 60) begin
         @(negedge clk);
         el++;
      end
      chk("ready_before_send", in_ready, 1);
      in_valid = 1'b1;
      x_in     = xv[15:0];
      d_in     = dv[15:0];
      adapt_en = ad;
      model_step(xv, dv, ad, y, e);
      @(negedge clk);
      in_valid = 1'b0;
      el = 0;
      while (!out_valid && el < 60) begin
         @(negedge clk);
         el++;
      end
      chk("out_valid_latency", el, TAPS + 1);
      chk("y_out", y_out, y);
      chk("e_out", e_out, e);
      while (!in_ready && el < 60) begin
         @(negedge clk);
         el++;
      end
      chk("in_ready_return", el, ad ? 2 * TAPS + 1 : TAPS + 1);
   endtask

   task automatic readback(input string tag);
      for (int i = 0; i < TAPS; i++) begin
         coef_sel = i[1:0];
         @(negedge clk);
         chk($sformatf("%s_w%0d", tag, i), coef_out, mw[i]);
      end
   endtask

   task automatic clr_pulse();
      coef_clr = 1'b1;
      @(negedge clk);
      coef_clr = 1'b0;
      model_clear();
   endtask

   initial begin
      int     el;
      bit     saw;
      int     xv, dv;
      int     qx [TAPS];
      longint y, e;
      longint tgt [TAPS];

      rst = 1'b1; in_valid = 1'b0; x_in = '0; d_in = '0;
      adapt_en = 1'b0; coef_clr = 1'b0; coef_sel = '0;
      model_clear();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_e_out", e_out, 0);
      chk("rst_coef_out", coef_out, 0);
      rst = 1'b0;
      @(negedge clk);
      readback("after_reset");

      // First sample with adaptation: w0 becomes 500*1000 >>> 12 = 122
      send(1000, 500, 1'b1);
      chk("first_w0_const", mw[0], 122);
      readback("first_sample");

      // Frozen adaptation with random samples
      for (int n = 0; n < 10; n++) begin
         xv = int'($urandom_range(65535, 0)) - 32768;
         dv = int'($urandom_range(65535, 0)) - 32768;
         send(xv, dv, 1'b0);
      end
      readback("freeze");

      // coef_clr in the middle of UPD
      el = 0;
      while (!in_ready && el < 60) begin
         @(negedge clk);
         el++;
      end
      chk("clr_upd_ready", in_ready, 1);
      in_valid = 1'b1; x_in = 16'sd3000; d_in = -16'sd2000; adapt_en = 1'b1;
      model_step(3000, -2000, 1'b1, y, e);
      @(negedge clk);
      in_valid = 1'b0;
      el = 0;
      while (!out_valid && el < 60) begin
         @(negedge clk);
         el++;
      end
      chk("clr_upd_latency", el, TAPS + 1);
      chk("clr_upd_y", y_out, y);
      chk("clr_upd_e", e_out, e);
      @(negedge clk);
      coef_clr = 1'b1;
      #1 chk("clr_upd_ready_low", in_ready, 0);
      @(negedge clk);
      coef_clr = 1'b0;
      model_clear();
      #1 chk("clr_upd_ready_after", in_ready, 1);
      readback("clr_mid_upd");

      // coef_clr together with in_valid in IDLE: sample must be dropped
      in_valid = 1'b1; x_in = 16'sd5000; d_in = 16'sd100; adapt_en = 1'b1; coef_clr = 1'b1;
      #1 chk("clr_valid_ready_low", in_ready, 0);
      @(negedge clk);
      coef_clr = 1'b0; in_valid = 1'b0;
      model_clear();
      #1 chk("clr_valid_ready_after", in_ready, 1);
      saw = 1'b0;
      repeat (TAPS + 3) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk("clr_valid_no_out_valid", saw, 0);
      readback("clr_valid_zero");
      send(1000, 500, 1'b1);
      readback("clr_valid_history");

      // Saturation
      clr_pulse();
      send(32767, 32767, 1'b1);
      chk("sat_w0_const", mw[0], 32767);
      readback("sat_w");
      send(32767, -32768, 1'b0);
      chk("sat_y_const", y_out, 32767);
      chk("sat_e_const", e_out, -32768);

      // Convergence towards (0.5, -0.25, 0.125, 0) in Q2.14
      clr_pulse();
      for (int k = 0; k < TAPS; k++) qx[k] = 0;
      tgt[0] = 8192; tgt[1] = -4096; tgt[2] = 2048; tgt[3] = 0;
      for (int n = 0; n < 3000; n++) begin
         xv = int'($urandom_range(16000, 0)) - 8000;
         for (int k = TAPS - 1; k > 0; k--) qx[k] = qx[k-1];
         qx[0] = xv;
         dv = int'((longint'(8192) * qx[0] - longint'(4096) * qx[1]
                   + longint'(2048) * qx[2]) >>> FRAC);
         send(xv, dv, 1'b1);
      end
      chk("conv_err_small", (e_out < 16'sd64) && (e_out > -16'sd64), 1);
      readback("conv_model");
      for (int i = 0; i < TAPS; i++) begin
         coef_sel = i[1:0];
         @(negedge clk);
         chk($sformatf("conv_near_w%0d", i),
             (longint'(coef_out) - tgt[i] <= 64) && (tgt[i] - longint'(coef_out) <= 64), 1);
      end

      // Asynchronous reset in the middle of FILT
      coef_sel = 2'd0;
      @(negedge clk);
      in_valid = 1'b1; x_in = 16'sd1234; d_in = 16'sd4321; adapt_en = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_y_out", y_out, 0);
      chk("arst_e_out", e_out, 0);
      chk("arst_coef_out", coef_out, 0);
      chk("arst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1 chk("arst_ready_after", in_ready, 1);
      saw = 1'b0;
      repeat (TAPS + 3) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      chk("arst_no_out_valid", saw, 0);
      send(1000, 500, 1'b1);
      readback("arst_next_sample");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
